// File: rtl/wb_line_bridge_if.sv
// Wishbone line-bus bundle between wb_line_bridge (master) and a line-wide slave.
// The address field carries line addresses, so its width drops the in-line offset bits.
interface wb_line_bridge_if #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
);
    localparam int OFF = $clog2(LINE_W / 8);

    logic [ADDR_W-OFF-1:0] wb_adr;
    logic [LINE_W-1:0]     wb_dat_m;
    logic [LINE_W-1:0]     wb_dat_s;
    logic [LINE_W/8-1:0]   wb_sel;
    logic                  wb_we;
    logic                  wb_stb;
    logic                  wb_cyc;
    logic                  wb_ack;
    logic                  wb_rty;

    modport master (
        output wb_adr, wb_dat_m, wb_sel, wb_we, wb_stb, wb_cyc,
        input  wb_dat_s, wb_ack, wb_rty
    );

    modport slave (
        input  wb_adr, wb_dat_m, wb_sel, wb_we, wb_stb, wb_cyc,
        output wb_dat_s, wb_ack, wb_rty
    );
endinterface

// File: rtl/wb_line_bridge.sv
// Single-word CPU request to line-wide Wishbone bridge with bounded RTY retries.
// Optional bus watchdog enabled by defining WB_BRIDGE_TIMEOUT_EN.
module wb_line_bridge #(
    parameter int WORD_W    = 16,
    parameter int LINE_W    = 128,
    parameter int ADDR_W    = 16,
    parameter int MAX_RETRY = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [WORD_W-1:0]   req_wdata,
    input  logic [WORD_W/8-1:0] req_wmask,
    output logic                resp,
    output logic [WORD_W-1:0]   rdata,
    output logic                err,
    output logic                busy,
    wb_line_bridge_if.master    wb
);
    localparam int LANES     = LINE_W / WORD_W;
    localparam int OFF       = $clog2(LINE_W / 8);
    localparam int LSB       = $clog2(WORD_W / 8);
    localparam int BE_W      = WORD_W / 8;
    localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int RTY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUS     = 2'd1;
    localparam logic [1:0] S_BACKOFF = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]            state_q,  state_d;
    logic [RTY_W-1:0]      retry_q,  retry_d;
    logic [LANE_BITS-1:0]  lane_q,   lane_d;
    logic                  write_q,  write_d;
    logic                  resp_q,   resp_d;
    logic                  err_q,    err_d;
    logic                  busy_q,   busy_d;
    logic [WORD_W-1:0]     rdata_q,  rdata_d;
    logic [ADDR_W-OFF-1:0] adr_q,    adr_d;
    logic [LINE_W-1:0]     dat_q,    dat_d;
    logic [LINE_W/8-1:0]   sel_q,    sel_d;
    logic                  we_q,     we_d;
    logic                  stb_q,    stb_d;

    logic [LANE_BITS-1:0]  lane_in_s;
    logic [LINE_W-1:0]     dat_line_s;
    logic [LINE_W/8-1:0]   sel_line_s;
    logic [WORD_W-1:0]     rd_lane_s;

`ifdef WB_BRIDGE_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;
`endif

    // Sub-word address bits never reach the bus; the name keeps them out of lint.
    generate
        if (LSB > 0) begin : g_low_bits
            logic unused_low_s;
            assign unused_low_s = ^req_addr[LSB-1:0];
        end
    endgenerate

    // Lane index of the incoming request within its line.
    always_comb begin
        lane_in_s = (LANES > 1) ? LANE_BITS'(req_addr[ADDR_W-1:LSB]) : '0;
    end

    // Place the store word and its byte enables into the selected lane only.
    always_comb begin
        dat_line_s = '0;
        sel_line_s = '0;
        for (int i = 0; i < LANES; i++) begin
            dat_line_s[i*WORD_W +: WORD_W] = (lane_in_s == LANE_BITS'(i)) ? req_wdata : {WORD_W{1'b0}};
            sel_line_s[i*BE_W +: BE_W]     = (lane_in_s == LANE_BITS'(i)) ?
                                             (req_write ? req_wmask : {BE_W{1'b1}}) : {BE_W{1'b0}};
        end
    end

    // Pick the latched lane out of the returned slave line.
    always_comb begin
        rd_lane_s = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_lane_s = (lane_q == LANE_BITS'(i)) ? wb.wb_dat_s[i*WORD_W +: WORD_W] : rd_lane_s;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lane_d  = lane_q;
        write_d = write_q;
        rdata_d = rdata_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
`ifdef WB_BRIDGE_TIMEOUT_EN
        wdog_d  = wdog_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_BUS;
                    retry_d = '0;
                    lane_d  = lane_in_s;
                    write_d = req_write;
                    adr_d   = req_addr[ADDR_W-1:OFF];
                    dat_d   = dat_line_s;
                    sel_d   = sel_line_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUS: begin
                if (wb.wb_ack) begin
                    rdata_d = rd_lane_s;
                    state_d = S_DONE;
                end else if (wb.wb_rty) begin
                    if (retry_q == RTY_W'(MAX_RETRY)) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = S_BACKOFF;
                    end
                end else begin
`ifdef WB_BRIDGE_TIMEOUT_EN
                    if (wdog_q == 16'd1023) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        wdog_d  = wdog_q + 16'd1;
                    end
`else
                    state_d = S_BUS;
`endif
                end
            end
            S_BACKOFF: state_d = S_BUS;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
`ifdef WB_BRIDGE_TIMEOUT_EN
        wdog_d = ((state_d == S_BUS) && (state_q != S_BUS)) ? 16'd0 : wdog_d;
`endif
        stb_d  = (state_d == S_BUS);
        we_d   = (state_d == S_BUS) && write_d;
        resp_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset also drops the bus strobe mid-cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            retry_q <= '0;
            lane_q  <= '0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            lane_q  <= lane_d;
            write_q <= write_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
        end
    end

`ifdef WB_BRIDGE_TIMEOUT_EN
    // Watchdog counter of cycles spent waiting in BUS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= 16'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign resp        = resp_q;
    assign rdata       = rdata_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign wb.wb_adr   = adr_q;
    assign wb.wb_dat_m = dat_q;
    assign wb.wb_sel   = sel_q;
    assign wb.wb_we    = we_q;
    assign wb.wb_stb   = stb_q;
    assign wb.wb_cyc   = stb_q;
endmodule
